// File: rtl/fmc_mmu_pkg.sv
// Shared types and constants for the FMC-to-BRAM bridge: FSM states, access
// classes, control-register indices and STATUS bit positions.
package fmc_mmu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_WAIT,
        ST_RD_DRIVE,
        ST_HOLD
    } state_e;

    typedef enum logic [1:0] {
        ACC_BRAM,
        ACC_CTL,
        ACC_UNMAP
    } acc_e;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_STATUS   = 3'd1;
    localparam logic [2:0] REG_DOORBELL = 3'd2;
    localparam logic [2:0] REG_SCRATCH  = 3'd3;
    localparam logic [2:0] REG_WR_COUNT = 3'd4;
    localparam logic [2:0] REG_ID       = 3'd5;

    localparam int ST_DOORBELL_BIT = 0;
    localparam int ST_ERR_BIT      = 1;

endpackage

// File: rtl/fmc_mmu_regs.sv
// Control register file: CTRL, W1C STATUS, DOORBELL, SCRATCH, WR_COUNT, ID.
// Writes and event pulses land on the clock edge; mmu_int is registered from STATUS.
module fmc_mmu_regs
    import fmc_mmu_pkg::*;
#(
    parameter int          DW     = 32,
    parameter logic [DW-1:0] ID_VAL = 32'hC0DE_0002
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_i,
    input  logic [2:0]    idx_i,
    input  logic [DW-1:0] wdat_i,
    input  logic          bram_wr_i,
    input  logic          err_i,
    output logic [DW-1:0] rdat_o,
    output logic          irq_o
);

    logic          irq_en_q;
    logic [1:0]    status_q, status_d;
    logic [DW-1:0] scratch_q;
    logic [DW-1:0] wr_count_q;
    logic          irq_q;

    // Clear first, then apply sets, so a simultaneous set survives the W1C.
    always_comb begin
        status_d = status_q;
        if (wr_i && idx_i == REG_STATUS) status_d = status_q & ~wdat_i[1:0];
        if (wr_i && idx_i == REG_DOORBELL) status_d[ST_DOORBELL_BIT] = 1'b1;
        if (err_i) status_d[ST_ERR_BIT] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_en_q   <= 1'b0;
            status_q   <= '0;
            scratch_q  <= '0;
            wr_count_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            if (wr_i && idx_i == REG_CTRL)    irq_en_q  <= wdat_i[0];
            if (wr_i && idx_i == REG_SCRATCH) scratch_q <= wdat_i;
            if (bram_wr_i) wr_count_q <= wr_count_q + DW'(1);
            status_q <= status_d;
            irq_q    <= irq_en_q & (|status_q);
        end
    end

    always_comb begin
        rdat_o = '0;
        case (idx_i)
            REG_CTRL:     rdat_o = {{(DW-1){1'b0}}, irq_en_q};
            REG_STATUS:   rdat_o = {{(DW-2){1'b0}}, status_q};
            REG_SCRATCH:  rdat_o = scratch_q;
            REG_WR_COUNT: rdat_o = wr_count_q;
            REG_ID:       rdat_o = ID_VAL;
            default:      rdat_o = '0;
        endcase
    end

    assign irq_o = irq_q;

endmodule

// File: rtl/fmc_mmu_bridge.sv
// Synchronous FMC slave mapping a host window onto BRAMS BRAM banks plus a control bank.
// Reads hold fmc_nwait low for READ_LAT clocks after the bank enable; one access per ne assertion.
module fmc_mmu_bridge
    import fmc_mmu_pkg::*;
#(
    parameter int            FMC_AW    = 20,
    parameter int            BRAM_AW   = 12,
    parameter int            DW        = 32,
    parameter int            BRAMS     = 9,
    parameter int            CTL_REGS  = 6,
    parameter int            READ_LAT  = 1,
    parameter logic [DW-1:0] ID_VAL    = 32'hC0DE_0002,
    parameter logic [DW-1:0] UNMAP_VAL = 32'hDEAD_BEEF
) (
    input  logic                fmc_clk,
    input  logic                rst,
    input  logic [FMC_AW-1:0]   fmc_a,
    input  logic                fmc_ne,
    input  logic                fmc_noe,
    input  logic                fmc_nwe,
    inout  wire  [DW-1:0]       fmc_d,
    output logic                fmc_nwait,
    output logic                mmu_int,
    output logic [BRAM_AW-1:0]  bram_a,
    output logic [DW-1:0]       bram_do,
    output logic [BRAMS-1:0]    bram_en,
    output logic                bram_we,
    input  logic [BRAMS*DW-1:0] bram_di
);

    localparam int BANK_W = FMC_AW - BRAM_AW;

    function automatic acc_e decode(input logic [FMC_AW-1:0] a);
        logic [BANK_W-1:0] bank;
        bank = a[FMC_AW-1:BRAM_AW];
        if (int'(bank) < BRAMS) return ACC_BRAM;
        if (int'(bank) == BRAMS) return (int'(a[2:0]) < CTL_REGS) ? ACC_CTL : ACC_UNMAP;
        return ACC_UNMAP;
    endfunction

    state_e             state_q;
    acc_e               acc_q;
    logic [BANK_W-1:0]  bank_q;
    logic [2:0]         idx_q;
    logic [DW-1:0]      wdat_q;
    logic [1:0]         cnt_q;
    logic [DW-1:0]      rdata_q;
    logic               drive_q;
    logic               nwait_q;
    logic [BRAMS-1:0]   bram_en_q;
    logic               bram_we_q;
    logic [BRAM_AW-1:0] bram_a_q;
    logic [DW-1:0]      bram_do_q;

    acc_e              in_acc;
    logic [BANK_W-1:0] in_bank;
    logic              rd_cap;
    logic              ctl_wr;
    logic              bram_wr;
    logic              err_set;
    logic [DW-1:0]     ctl_rdat;
    logic [DW-1:0]     bram_rd;
    logic              irq;

    assign in_acc  = decode(fmc_a);
    assign in_bank = fmc_a[FMC_AW-1:BRAM_AW];
    assign rd_cap  = (state_q == ST_RD_WAIT) && !fmc_ne && (cnt_q == 2'(READ_LAT - 1));
    assign ctl_wr  = (state_q == ST_WR) && (acc_q == ACC_CTL);
    assign bram_wr = (state_q == ST_WR) && (acc_q == ACC_BRAM);
    assign err_set = ((state_q == ST_WR) || rd_cap) && (acc_q == ACC_UNMAP);
    assign bram_rd = bram_di[DW*int'(bank_q) +: DW];

    fmc_mmu_regs #(
        .DW     (DW),
        .ID_VAL (ID_VAL)
    ) u_regs (
        .clk_i     (fmc_clk),
        .rst_i     (rst),
        .wr_i      (ctl_wr),
        .idx_i     (idx_q),
        .wdat_i    (wdat_q),
        .bram_wr_i (bram_wr),
        .err_i     (err_set),
        .rdat_o    (ctl_rdat),
        .irq_o     (irq)
    );

    always_ff @(posedge fmc_clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= ACC_UNMAP;
            bank_q    <= '0;
            idx_q     <= '0;
            wdat_q    <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            drive_q   <= 1'b0;
            nwait_q   <= 1'b1;
            bram_en_q <= '0;
            bram_we_q <= 1'b0;
            bram_a_q  <= '0;
            bram_do_q <= '0;
        end else begin
            bram_en_q <= '0;
            bram_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!fmc_ne && (!fmc_nwe || !fmc_noe)) begin
                        acc_q  <= in_acc;
                        bank_q <= in_bank;
                        idx_q  <= fmc_a[2:0];
                        if (in_acc == ACC_BRAM) begin
                            bram_en_q <= BRAMS'(1) << in_bank;
                            bram_a_q  <= fmc_a[BRAM_AW-1:0];
                        end
                        if (!fmc_nwe) begin
                            wdat_q  <= fmc_d;
                            state_q <= ST_WR;
                            if (in_acc == ACC_BRAM) begin
                                bram_we_q <= 1'b1;
                                bram_do_q <= fmc_d;
                            end
                        end else begin
                            cnt_q   <= '0;
                            nwait_q <= 1'b0;
                            state_q <= ST_RD_WAIT;
                        end
                    end
                end
                ST_WR: state_q <= ST_HOLD;
                ST_RD_WAIT: begin
                    // Host gave up before data was ready: drop the access silently.
                    if (fmc_ne) begin
                        nwait_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (rd_cap) begin
                        case (acc_q)
                            ACC_BRAM: rdata_q <= bram_rd;
                            ACC_CTL:  rdata_q <= ctl_rdat;
                            default:  rdata_q <= UNMAP_VAL;
                        endcase
                        drive_q <= 1'b1;
                        nwait_q <= 1'b1;
                        state_q <= ST_RD_DRIVE;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                ST_RD_DRIVE: begin
                    if (fmc_ne || fmc_noe) begin
                        drive_q <= 1'b0;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: if (fmc_ne) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fmc_d     = drive_q ? rdata_q : {DW{1'bz}};
    assign fmc_nwait = nwait_q;
    assign mmu_int   = irq;
    assign bram_a    = bram_a_q;
    assign bram_do   = bram_do_q;
    assign bram_en   = bram_en_q;
    assign bram_we   = bram_we_q;

endmodule

// File: doc/fmc_mmu_bridge.md
Name: fmc_mmu_bridge

Overview:
Synchronous FMC slave that maps a host memory window onto BRAMS parallel BRAM banks plus a small control-register bank. It is the parametrised successor of the current FMC-to-BRAM bridge, and adds:
- configurable BRAM read latency, with FMC wait-state (nwait) generation;
- unmapped-access detection;
- a doorbell/status interrupt path driving mmu_int.
It sits between the board-level FMC pins and the bram_mtrx instances in crystal_top.

Parameters:
FMC_AW, 20, FMC word-address width
BRAM_AW, 12, word-address width inside one BRAM bank
DW, 32, data width of FMC and BRAM port A
BRAMS, 9, number of BRAM banks
CTL_REGS, 6, number of control registers (min 6)
READ_LAT, 1, BRAM read latency in clocks, legal 1..4
ID_VAL, 32'hC0DE_0002, value returned by ID register
UNMAP_VAL, 32'hDEAD_BEEF, read data for unmapped addresses

Ports:
fmc_clk  in  1  single clock, FMC synchronous-mode clock
rst  in  1  synchronous, active-high reset
fmc_a  in  FMC_AW  word address
fmc_ne  in  1  chip select, active low
fmc_noe  in  1  output enable, active low
fmc_nwe  in  1  write enable, active low
fmc_d  inout  DW  bidirectional data
fmc_nwait  out  1  wait, active low
mmu_int  out  1  interrupt to host, active high
bram_a  out  BRAM_AW  shared BRAM address
bram_do  out  DW  shared BRAM write data
bram_en  out  BRAMS  one-hot bank enable
bram_we  out  1  BRAM write enable
bram_di  in  BRAMS*DW  concatenated bank read data, bank i at [DW*(i+1)-1 -: DW]

Behaviour:
Clocking and reset:
- One clock (fmc_clk). Reset is synchronous and active-high (rst).
- Reset values: bram_en=0, bram_we=0, bram_a=0, bram_do=0, fmc_d hi-Z, fmc_nwait=1, mmu_int=0, all registers 0, FSM in IDLE.

Address decode (on the sampled fmc_a):
- offset = fmc_a[BRAM_AW-1:0]; bank = fmc_a[FMC_AW-1:BRAM_AW].
- bank < BRAMS: BRAM access.
- bank == BRAMS: control register fmc_a[2:0]; indices >= CTL_REGS are unmapped.
- Anything else is unmapped.

FSM states: IDLE, WR, RD_WAIT, RD_DRIVE, HOLD.
- IDLE: start a transaction on the first edge where fmc_ne=0.
  - If fmc_nwe=0, latch address and data and go to WR. A write takes priority if nwe and noe are both low.
  - Else if fmc_noe=0, go to RD_WAIT.
  - Else stay in IDLE.
- WR (1 cycle):
  - BRAM access: bram_en[bank]=1, bram_we=1, bram_a=offset, bram_do=data, asserted for exactly one cycle; WR_COUNT increments.
  - Control access: update the register.
  - Unmapped: no effect; set STATUS.err.
  - Then go to HOLD.
- RD_WAIT:
  - Pulse bram_en[bank] for one cycle with bram_we=0.
  - fmc_nwait=0 from the cycle after ne is sampled low.
  - Wait READ_LAT cycles. Capture the bram_di slice, the control register, or UNMAP_VAL into the output register (unmapped sets STATUS.err).
  - Then go to RD_DRIVE.
- RD_DRIVE: drive fmc_d and set fmc_nwait=1. Keep driving while ne=0 and noe=0. When either goes high, release fmc_d on the next edge and go to HOLD.
- HOLD: wait for fmc_ne=1, then go to IDLE. Exactly one access per ne assertion; no bursts.

Control registers:
- 0 CTRL (rw): bit0 irq_en.
- 1 STATUS (W1C): bit0 doorbell, bit1 err.
- 2 DOORBELL (wo): any write sets STATUS.doorbell; reads return 0.
- 3 SCRATCH (rw).
- 4 WR_COUNT (ro): DW-bit count of BRAM writes, wraps at 2^DW-1 -> 0.
- 5 ID (ro): ID_VAL.

Interrupt:
- mmu_int is registered: mmu_int <= irq_en & (doorbell | err).
- A set and a W1C clear in the same cycle: set wins.

Abort:
- fmc_ne deasserting before read data is ready: abort to IDLE; fmc_d is never driven and fmc_nwait returns to 1 next edge.
- rst mid-transaction: all outputs take their reset values at that edge.

Decomposition:
- Package fmc_mmu_pkg: FSM state enum; control-register index constants (CTRL, STATUS, DOORBELL, SCRATCH, WR_COUNT, ID); STATUS bit positions.
- Sub-module fmc_mmu_regs: control register file, W1C logic, WR_COUNT, interrupt generation.
- Top holds decode, FSM and tristate.

Test Plan:
- Write 0x12345678 to bank 3, offset 0x005 -> one cycle with bram_en=9'b000001000, bram_we=1, bram_a=0x005, bram_do=0x12345678; WR_COUNT reads 1.
- READ_LAT=2, read bank 0 with bram_di slice 0 = 0xA5A5A5A5 -> fmc_nwait low for 2 cycles; fmc_d=0xA5A5A5A5 until noe high; then hi-Z.
- Write CTRL=1, then DOORBELL -> mmu_int=1 the cycle after STATUS sets; write STATUS=1 -> mmu_int=0 next cycle.
- Read bank 15 -> fmc_d=0xDEADBEEF, STATUS=0x2, no bram_en pulse; write bank 15 -> no bram_we.
- nwe=0 and noe=0 together -> treated as a write, fmc_d never driven; read ID -> 0xC0DE0002.
- Assert rst during RD_WAIT -> next edge fmc_nwait=1, fmc_d hi-Z, bram_en=0, FSM in IDLE.
